spi_req_arbiter: RTL

- Round-robin arbiter/sequencer sharing one 12-bit SPI master (newd/din in, cs out) between NUM_REQ requesters.
- Latches the winner's word and issues a one-cycle newd pulse.
- Tracks the transfer via the master's cs, then returns a done pulse to the winner.
- Sits between the command sources and the SPI master, in the same clk domain.

---
 rtl/spi_arb_pkg.sv | 16 +
 rtl/spi_req_arbiter_if.sv | 26 ++
 rtl/spi_req_arbiter_rr_picker.sv | 29 ++
 rtl/spi_req_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/spi_arb_pkg.sv
// Shared types and default constants for the SPI request arbiter.
package spi_arb_pkg;

    localparam int DEF_DATA_W      = 12;
    localparam int DEF_GAP_CYC     = 2;
    localparam int DEF_TIMEOUT_CYC = 512;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LAUNCH     = 3'd1,
        WAIT_START = 3'd2,
        WAIT_END   = 3'd3,
        GAP        = 3'd4
    } spi_arb_state_t;

endpackage

// File: rtl/spi_req_arbiter_if.sv
// Bundle between requesters, the arbiter and the SPI master.
// master modport is the arbiter's view; slave is the surrounding environment.
interface spi_req_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = spi_arb_pkg::DEF_DATA_W
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic                      spi_newd;
    logic [DATA_W-1:0]         spi_din;
    logic                      spi_cs;
    logic                      busy;
    logic                      err;

    modport master (
        input  req, req_data, spi_cs,
        output gnt, done, spi_newd, spi_din, busy, err
    );

    modport slave (
        output req, req_data, spi_cs,
        input  gnt, done, spi_newd, spi_din, busy, err
    );
endinterface

// File: rtl/spi_req_arbiter_rr_picker.sv
// Combinational round-robin select: first set request at or after ptr, wrapping.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] win,
    output logic [PTR_W-1:0]   win_idx,
    output logic               valid
);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    always_comb begin
        logic [PTR_W-1:0] idx;
        win     = '0;
        win_idx = '0;
        valid   = 1'b0;
        idx     = ptr;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!valid && req[idx]) begin
                valid   = 1'b1;
                win_idx = idx;
            end
            idx = (idx == LAST_IDX) ? '0 : idx + PTR_W'(1);
        end
        win[win_idx] = valid;
    end
endmodule

// File: rtl/spi_req_arbiter.sv
// Round-robin sequencer sharing one SPI master between NUM_REQ requesters.
// Define SPI_ARB_TIMEOUT_EN to build the cs watchdog and the err pulse.
module spi_req_arbiter
    import spi_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic               clk,
    input logic               rst,
    spi_req_arbiter_if.master bus
);
    localparam int PTR_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);
    localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    spi_arb_state_t     state;
    logic [PTR_W-1:0]   ptr, cur_idx, nxt_ptr, pick_idx;
    logic [NUM_REQ-1:0] pick_win, gnt_q, done_q;
    logic               pick_vld, newd_q, busy_q, xfer_end, timeout_hit;
    logic [DATA_W-1:0]  din_q;
    logic [GAP_W-1:0]   gap_cnt;

    rr_picker #(.NUM_REQ(NUM_REQ), .PTR_W(PTR_W)) u_pick (
        .req     (bus.req),
        .ptr     (ptr),
        .win     (pick_win),
        .win_idx (pick_idx),
        .valid   (pick_vld)
    );

    assign nxt_ptr  = (cur_idx == LAST_IDX) ? '0 : cur_idx + PTR_W'(1);
    // A transfer ends on the cs rising edge or, when built in, on watchdog expiry.
    assign xfer_end = timeout_hit || (state == WAIT_END && bus.spi_cs);

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int WDT_W = $clog2(TIMEOUT_CYC + 1);
    logic [WDT_W-1:0] wdt;
    logic             err_q;

    assign timeout_hit = (state == WAIT_START || state == WAIT_END) &&
                         (wdt == WDT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            wdt   <= '0;
            err_q <= 1'b0;
        end else begin
            err_q <= timeout_hit;
            if (state == WAIT_START || state == WAIT_END) wdt <= wdt + WDT_W'(1);
            else                                          wdt <= '0;
        end
    end

    assign bus.err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign bus.err     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= '0;
            cur_idx <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
            newd_q  <= 1'b0;
            din_q   <= '0;
            busy_q  <= 1'b0;
            gap_cnt <= '0;
        end else begin
            newd_q <= 1'b0;
            done_q <= '0;
            if (xfer_end) begin
                done_q  <= gnt_q;
                gnt_q   <= '0;
                ptr     <= nxt_ptr;
                gap_cnt <= '0;
                if (GAP_CYC == 0) begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end else begin
                    state <= GAP;
                end
            end else begin
                case (state)
                    IDLE: if (pick_vld) begin
                        gnt_q   <= pick_win;
                        cur_idx <= pick_idx;
                        din_q   <= bus.req_data[int'(pick_idx)*DATA_W +: DATA_W];
                        newd_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        state   <= LAUNCH;
                    end
                    LAUNCH:     state <= WAIT_START;
                    WAIT_START: if (!bus.spi_cs) state <= WAIT_END;
                    WAIT_END:   begin end
                    // Requests arriving here stay pending on req and are picked up in IDLE.
                    GAP: begin
                        if (gap_cnt == GAP_LAST) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + GAP_W'(1);
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.spi_newd = newd_q;
    assign bus.spi_din  = din_q;
    assign bus.busy     = busy_q;
endmodule
